// File: rtl/deser_pkg.sv
// Shared types and constants for the serial deserializer.
package deser_pkg;

  // Frame state: IDLE holds no bits, SHIFT holds 1..WIDTH-1 bits of a partial word.
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } deser_state_e;

  // Default word width.
  localparam int unsigned DESER_W = 8;

  // Bit counter width: enough to hold values 0..width.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/deser_bitcnt.sv
// Bit counter for the deserializer: counts accepted bits within a word, restarts on sync,
// and flags the terminal count (WIDTH-1 bits already held).
module deser_bitcnt
  import deser_pkg::*;
#(
  parameter int unsigned WIDTH = DESER_W
) (
  input  logic clk_i,
  input  logic clr_i,
  input  logic sync_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int unsigned CntW = cnt_width(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tc_o = (cnt_q == CntLast);

  // Next count: sync restarts (counting a coincident bit as bit 0), completion wraps to 0.
  always_comb begin
    cnt_d = cnt_q;
    if (sync_i) begin
      cnt_d = en_i ? CntW'(1) : '0;
    end else if (en_i) begin
      cnt_d = tc_o ? '0 : cnt_q + CntW'(1);
    end
  end

  // Count register with asynchronous clear.
  always_ff @(posedge clk_i or posedge clr_i) begin
    if (clr_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/serial_deser.sv
// Serial-in, parallel-out deserializer with valid/ack output register and sticky overrun.
module serial_deser
  import deser_pkg::*;
#(
  parameter int unsigned WIDTH     = DESER_W,
  parameter bit          LSB_FIRST = 1'b0
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             sin_i,
  input  logic             sen_i,
  input  logic             sync_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             dout_vld_o,
  input  logic             dout_ack_i,
  output logic             busy_o,
  output logic             ovr_o,
  input  logic             ovr_clr_i
);

  deser_state_e     state_q;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] word_nxt;
  logic [WIDTH-1:0] word_first;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             vld_q, vld_d;
  logic             ovr_q, ovr_d;
  logic             cnt_tc;
  logic             complete;
  logic             overrun;

  deser_bitcnt #(
    .WIDTH (WIDTH)
  ) u_bitcnt (
    .clk_i  (clk_i),
    .clr_i  (clr_i),
    .sync_i (sync_i),
    .en_i   (sen_i),
    .tc_o   (cnt_tc)
  );

  // Word with the current input bit shifted in, and a fresh word holding only that bit.
  assign word_nxt   = LSB_FIRST ? {sin_i, shift_q[WIDTH-1:1]} : {shift_q[WIDTH-2:0], sin_i};
  assign word_first = LSB_FIRST ? {sin_i, {(WIDTH-1){1'b0}}} : {{(WIDTH-1){1'b0}}, sin_i};

  // A sync in the completing cycle discards the word instead of completing it.
  assign complete = sen_i & ~sync_i & cnt_tc;
  assign overrun  = complete & vld_q & ~dout_ack_i;

  // Frame FSM; busy is a registered decode of the state.
  always_ff @(posedge clk_i or posedge clr_i) begin
    if (clr_i) begin
      state_q <= ST_IDLE;
    end else if (sync_i) begin
      state_q <= sen_i ? ST_SHIFT : ST_IDLE;
    end else if (sen_i) begin
      state_q <= cnt_tc ? ST_IDLE : ST_SHIFT;
    end
  end

  assign busy_o = (state_q == ST_SHIFT);

  // Shift register next state; cleared after completion so each word starts from zero.
  always_comb begin
    shift_d = shift_q;
    if (sync_i) begin
      shift_d = sen_i ? word_first : '0;
    end else if (sen_i) begin
      shift_d = cnt_tc ? '0 : word_nxt;
    end
  end

  // Output register and handshake: load when empty or being consumed, else drop and flag.
  always_comb begin
    dout_d = dout_q;
    vld_d  = vld_q;
    if (complete) begin
      if (!vld_q || dout_ack_i) begin
        dout_d = word_nxt;
        vld_d  = 1'b1;
      end
    end else if (vld_q && dout_ack_i) begin
      vld_d = 1'b0;
    end
  end

  // Sticky overrun; a new overrun wins over a coincident clear.
  always_comb begin
    ovr_d = ovr_q;
    if (overrun) begin
      ovr_d = 1'b1;
    end else if (ovr_clr_i) begin
      ovr_d = 1'b0;
    end
  end

  // Datapath registers with asynchronous clear.
  always_ff @(posedge clk_i or posedge clr_i) begin
    if (clr_i) begin
      shift_q <= '0;
      dout_q  <= '0;
      vld_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      shift_q <= shift_d;
      dout_q  <= dout_d;
      vld_q   <= vld_d;
      ovr_q   <= ovr_d;
    end
  end

  assign dout_o     = dout_q;
  assign dout_vld_o = vld_q;
  assign ovr_o      = ovr_q;

endmodule
